// File: rtl/mul_pkg.sv
// Shared definitions for the sequenced multiplier: FSM state encoding and default latency.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mul_state_t;

  localparam int unsigned MUL_LAT_DEFAULT = 2;

endpackage

// File: rtl/mul_32.sv
// Combinational 32x32 signed radix-4 Booth multiplier producing a 64-bit product as HI:LO.
module mul_32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [32:0] b_ext;
  logic [63:0] a_ext;
  logic [63:0] pp [16];
  logic [63:0] acc;

  assign b_ext = {B, 1'b0};
  assign a_ext = {{32{A[31]}}, A};

  // Each group looks at B[2g+1:2g-1] and selects 0, +-A or +-2A at weight 4^g.
  for (genvar g = 0; g < 16; g++) begin : g_pp
    logic [63:0] sel;
    always_comb begin
      sel = '0;
      case (b_ext[2*g+2 -: 3])
        3'b001, 3'b010: sel = a_ext;
        3'b011:         sel = a_ext << 1;
        3'b100:         sel = -(a_ext << 1);
        3'b101, 3'b110: sel = -a_ext;
        default:        sel = '0;
      endcase
    end
    assign pp[g] = sel << (2 * g);
  end

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      acc = acc + pp[i[3:0]];
    end
  end

  assign HI = acc[63:32];
  assign LO = acc[31:0];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multicycle sequencer around mul_32: holds operands LAT cycles, optionally applies the
// unsigned high-word correction, and reports completion with a busy/done handshake.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned LAT = MUL_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        is_unsigned,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mul_state_t  state;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_u;
  logic [3:0]  cnt;
  logic [63:0] prod;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic [31:0] hi_fix;

  mul_32 u_mul (
    .A  (op_a),
    .B  (op_b),
    .HI (mul_hi),
    .LO (mul_lo)
  );

  // Signed-to-unsigned conversion of the high word: add back b when a was negative and vice versa.
  assign hi_fix = prod[63:32] + (op_a[31] ? op_b : '0) + (op_b[31] ? op_a : '0);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_u  <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_a  <= a;
            op_b  <= b;
            op_u  <= is_unsigned;
            cnt   <= 4'(LAT - 1);
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else if (!op_u) begin
            hi    <= mul_hi;
            lo    <= mul_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            prod  <= {mul_hi, mul_lo};
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
          if (!flush) begin
            hi   <= hi_fix;
            lo   <= prod[31:0];
            done <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
